// File: rtl/dmaunibus.sv
// dmaunibus - ARM-commanded Unibus master (initiator).
//
// The ARM loads an address, optional data and a command word. The block then
// requests the bus with NPR, acknowledges the grant with SACK, takes BBSY and
// runs a single DATI, DATO or DATOB cycle. The result is left in the ARM
// registers.
//
// Ports
//   CLOCK, RESET          system clock; synchronous active-high reset
//   armwrite/armwaddr/armwdata  ARM register write port (one-clock strobe)
//   armraddr/armrdata     ARM register read port (read data is combinational)
//   a/c/d_out_h           address, cycle type and write data driven during bus tenure
//   d_in_h                data returned by the slave
//   npr_out_h/npg_in_h    non-processor request and grant
//   sack_out_h            selection acknowledge
//   bbsy_in_h/bbsy_out_h  bus busy: from the other master / from this master
//   msyn_out_h/ssyn_in_h  master and slave sync
//   init_in_h             Unibus INIT; aborts a cycle that is in progress
//
// ARM registers
//   0  32'h444D1001 identification
//   1  {busy, write, byte, tmo, abt, 9'b0, addr[17:0]}   command / status
//   2  {16'b0, data[15:0]}                               write data / read result
//   3  32'hDEADBEEF
module dmaunibus #(
    parameter int DESKEW  = 15,    // clocks A/C/D are stable before MSYN (>= 1)
    parameter int TIMEOUT = 1000,  // clocks MSYN waits for SSYN (>= 1)
    parameter int HOLD    = 8      // clocks A/C/D are held after SSYN clears
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        armwrite,
    input  logic [1:0]  armraddr,
    input  logic [1:0]  armwaddr,
    input  logic [31:0] armwdata,
    output logic [31:0] armrdata,
    output logic [17:0] a_out_h,
    output logic [1:0]  c_out_h,
    output logic [15:0] d_out_h,
    input  logic [15:0] d_in_h,
    output logic        npr_out_h,
    input  logic        npg_in_h,
    output logic        sack_out_h,
    input  logic        bbsy_in_h,
    output logic        bbsy_out_h,
    output logic        msyn_out_h,
    input  logic        ssyn_in_h,
    input  logic        init_in_h
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_NPRREQ,
        ST_GRANTED,
        ST_SETUP,
        ST_MSYN,
        ST_RELEASE
    } state_t;

    localparam logic [15:0] DESKEW_LAST = 16'(DESKEW - 1);
    localparam logic [15:0] TMO_LAST    = 16'(TIMEOUT - 1);
    localparam logic [15:0] HOLD_CNT    = 16'(HOLD);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        write_q, write_d;
    logic        byte_q, byte_d;
    logic        tmo_q, tmo_d;
    logic        abt_q, abt_d;
    logic [17:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;

    // Command word bits 28:18 have no function.
    logic unused_wdata;
    assign unused_wdata = ^armwdata[28:18];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        write_d = write_q;
        byte_d  = byte_q;
        tmo_d   = tmo_q;
        abt_d   = abt_q;
        addr_d  = addr_q;
        data_d  = data_q;

        // Register writes are accepted only while no command is outstanding,
        // so the values driven onto the bus cannot change mid-cycle.
        if (armwrite && !busy_q) begin
            case (armwaddr)
                2'd1: begin
                    write_d = armwdata[30];
                    byte_d  = armwdata[29];
                    addr_d  = armwdata[17:0];
                    tmo_d   = 1'b0;
                    abt_d   = 1'b0;
                    busy_d  = armwdata[31];
                end
                2'd2: data_d = armwdata[15:0];
                default: ;
            endcase
        end

        // cnt_q is shared: deskew count in SETUP, timeout in MSYN, hold in RELEASE.
        case (state_q)
            ST_IDLE: begin
                if (busy_q) state_d = ST_NPRREQ;
            end
            ST_NPRREQ: begin
                if (npg_in_h) state_d = ST_GRANTED;
            end
            ST_GRANTED: begin
                // Take the bus only once the grant is gone and the previous master is off.
                if (!npg_in_h && !bbsy_in_h && !ssyn_in_h) begin
                    state_d = ST_SETUP;
                    cnt_d   = '0;
                end
            end
            ST_SETUP: begin
                if (cnt_q == DESKEW_LAST) begin
                    state_d = ST_MSYN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_MSYN: begin
                if (ssyn_in_h) begin
                    if (!write_q) data_d = d_in_h;
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                end else if (cnt_q == TMO_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                end else if (cnt_q != 16'hFFFF) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_RELEASE: begin
                // Hold count restarts while the slave still asserts SSYN.
                if (ssyn_in_h) begin
                    cnt_d = '0;
                end else if (cnt_q == HOLD_CNT) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // INIT drops everything; a command write in the same clock is already
        // blocked by busy_q.
        if (init_in_h && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            abt_d   = 1'b1;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            write_q <= 1'b0;
            byte_q  <= 1'b0;
            tmo_q   <= 1'b0;
            abt_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            write_q <= write_d;
            byte_q  <= byte_d;
            tmo_q   <= tmo_d;
            abt_q   <= abt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // Bus outputs decode straight from the state register, so any return to
    // IDLE (normal end, INIT, RESET) clears them on the same clock.
    always_comb begin
        npr_out_h  = 1'b0;
        sack_out_h = 1'b0;
        bbsy_out_h = 1'b0;
        msyn_out_h = 1'b0;
        a_out_h    = '0;
        c_out_h    = '0;
        d_out_h    = '0;
        case (state_q)
            ST_NPRREQ:  npr_out_h  = 1'b1;
            ST_GRANTED: sack_out_h = 1'b1;
            ST_SETUP, ST_MSYN, ST_RELEASE: begin
                bbsy_out_h = 1'b1;
                msyn_out_h = (state_q == ST_MSYN);
                a_out_h    = addr_q;
                // A byte read is issued as a word DATI.
                c_out_h    = {write_q, write_q & byte_q};
                // For DATOB software already placed the byte in its lane.
                d_out_h    = write_q ? data_q : 16'h0000;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (armraddr)
            2'd0:    armrdata = 32'h444D1001;
            2'd1:    armrdata = {busy_q, write_q, byte_q, tmo_q, abt_q, 9'b0, addr_q};
            2'd2:    armrdata = {16'b0, data_q};
            default: armrdata = 32'hDEADBEEF;
        endcase
    end

endmodule

// File: tb/tb_dmaunibus.sv
// Scoreboard bench for dmaunibus: each command pushes its expected final
// register contents; a monitor pops and compares when busy falls. Bus timing
// is checked inline by the stimulus, which also plays the Unibus slave.
module tb_dmaunibus;
    localparam int DESKEW = 15, TIMEOUT = 1000, HOLD = 8;

    logic        CLOCK = 1'b0, RESET = 1'b1;
    logic        armwrite = 1'b0;
    logic [1:0]  armraddr, armwaddr = 2'd0;
    logic [31:0] armwdata = '0, armrdata;
    logic [17:0] a_out_h;
    logic [1:0]  c_out_h;
    logic [15:0] d_out_h, d_in_h = '0;
    logic        npr_out_h, npg_in_h = 1'b0, sack_out_h, bbsy_in_h = 1'b0;
    logic        bbsy_out_h, msyn_out_h, ssyn_in_h = 1'b0, init_in_h = 1'b0;

    always #5 CLOCK = ~CLOCK;

    dmaunibus #(.DESKEW(DESKEW), .TIMEOUT(TIMEOUT), .HOLD(HOLD)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .armwrite(armwrite), .armraddr(armraddr),
        .armwaddr(armwaddr), .armwdata(armwdata), .armrdata(armrdata),
        .a_out_h(a_out_h), .c_out_h(c_out_h), .d_out_h(d_out_h), .d_in_h(d_in_h),
        .npr_out_h(npr_out_h), .npg_in_h(npg_in_h), .sack_out_h(sack_out_h),
        .bbsy_in_h(bbsy_in_h), .bbsy_out_h(bbsy_out_h), .msyn_out_h(msyn_out_h),
        .ssyn_in_h(ssyn_in_h), .init_in_h(init_in_h)
    );

    typedef struct {
        logic [31:0] r1;
        logic [31:0] r2;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0, failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mk_r1(input logic bsy, wr, by, tmo, abt, input logic [17:0] ad);
        return {bsy, wr, by, tmo, abt, 9'b0, ad};
    endfunction

    function automatic logic sig(input int sel);
        case (sel)
            0:       return npr_out_h;
            1:       return sack_out_h;
            2:       return bbsy_out_h;
            default: return msyn_out_h;
        endcase
    endfunction

    function automatic logic [63:0] bus_all();
        return 64'({npr_out_h, sack_out_h, bbsy_out_h, msyn_out_h, c_out_h, a_out_h, d_out_h});
    endfunction

    task automatic wait_for(input int sel, input logic val, input int lim, input string nm);
        int n = 0;
        while (sig(sel) !== val && n < lim) begin
            @(negedge CLOCK);
            n++;
        end
        if (sig(sel) !== val) begin
            checks++;
            failures++;
            $display("FAIL %s: timed out after %0d clocks", nm, lim);
        end
    endtask

    // Called at a negedge.
    task automatic arm_wr(input logic [1:0] wa, input logic [31:0] wd);
        armwaddr = wa;
        armwdata = wd;
        armwrite = 1'b1;
        @(negedge CLOCK);
        armwrite = 1'b0;
    endtask

    task automatic grant();
        wait_for(0, 1'b1, 20, "npr_assert");
        npg_in_h = 1'b1;
        @(negedge CLOCK);
        wait_for(1, 1'b1, 20, "sack_assert");
        npg_in_h = 1'b0;
        wait_for(2, 1'b1, 20, "bbsy_assert");
    endtask

    // Entered on the first negedge with bbsy high; returns with msyn high.
    task automatic deskew_check(input logic [17:0] ea, input logic [1:0] ec, input logic [15:0] ed);
        int n = 0, bad = 0;
        while (!msyn_out_h && n < 100) begin
            if ({a_out_h, c_out_h, d_out_h} !== {ea, ec, ed}) bad++;
            @(negedge CLOCK);
            n++;
        end
        chk("deskew_len", 64'(n), 64'(DESKEW));
        chk("deskew_acd_stable", 64'(bad), 64'd0);
        chk("msyn_acd", 64'({a_out_h, c_out_h, d_out_h}), 64'({ea, ec, ed}));
    endtask

    // Called at the first negedge where msyn reads 0 with ssyn low.
    task automatic hold_check(input string nm);
        int n = 0;
        @(negedge CLOCK);
        while (bbsy_out_h && n < 100) begin
            n++;
            @(negedge CLOCK);
        end
        chk({nm, "_hold_len"}, 64'(n), 64'(HOLD));
        chk({nm, "_outputs_idle"}, bus_all(), 64'd0);
    endtask

    // Slave answers dly clocks after msyn, keeps ssyn extra clocks after msyn drops.
    task automatic slave(input int dly, input logic [15:0] din, input int extra, input string nm);
        int bad = 0;
        repeat (dly) @(negedge CLOCK);
        ssyn_in_h = 1'b1;
        d_in_h    = din;
        @(negedge CLOCK);
        wait_for(3, 1'b0, 20, {nm, "_msyn_drop"});
        repeat (extra) begin
            if (!bbsy_out_h) bad++;
            @(negedge CLOCK);
        end
        chk({nm, "_held_under_ssyn"}, 64'(bad), 64'd0);
        ssyn_in_h = 1'b0;
        d_in_h    = '0;
        hold_check(nm);
    endtask

    // Monitor: owns armraddr; compares registers whenever busy falls.
    initial begin
        logic prev_busy;
        exp_t e;
        armraddr = 2'd1;
        wait (RESET == 1'b0);
        @(negedge CLOCK);
        armraddr = 2'd0; #1 chk("reg0_id", 64'(armrdata), 64'h444D1001);
        armraddr = 2'd3; #1 chk("reg3_const", 64'(armrdata), 64'hDEADBEEF);
        armraddr = 2'd2; #1 chk("reg2_reset", 64'(armrdata), 64'd0);
        armraddr = 2'd1; #1 chk("reg1_reset", 64'(armrdata), 64'd0);
        prev_busy = 1'b0;
        forever begin
            @(negedge CLOCK);
            #1;
            if (prev_busy && !armrdata[31]) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_completion: got r1=%h expected none", armrdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_status", 64'(armrdata), 64'(e.r1));
                    armraddr = 2'd2;
                    #1 chk("done_data", 64'(armrdata), 64'(e.r2));
                    armraddr = 2'd1;
                    #1;
                end
            end
            prev_busy = armrdata[31];
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad, n;
        repeat (3) @(negedge CLOCK);
        chk("reset_outputs", bus_all(), 64'd0);
        RESET = 1'b0;
        repeat (3) @(negedge CLOCK);

        // DATI 777570, slave answers 5 clocks after msyn with 123456.
        exp_q.push_back('{mk_r1(0, 0, 0, 0, 0, 18'o777570), 32'h0000A72E});
        arm_wr(2'd1, 32'h8000_0000 | 32'(18'o777570));
        grant();
        deskew_check(18'o777570, 2'b00, 16'h0000);
        slave(5, 16'o123456, 0, "dati");

        // DATO 777570 data 052525, slave holds ssyn 3 extra clocks.
        exp_q.push_back('{mk_r1(0, 1, 0, 0, 0, 18'o777570), 32'h00005555});
        arm_wr(2'd2, 32'(16'o052525));
        arm_wr(2'd1, 32'hC000_0000 | 32'(18'o777570));
        grant();
        deskew_check(18'o777570, 2'b10, 16'h5555);
        slave(2, 16'hFFFF, 3, "dato");

        // DATOB 777571 high lane; grant withheld 50 clocks.
        exp_q.push_back('{mk_r1(0, 1, 1, 0, 0, 18'o777571), 32'h0000AB00});
        arm_wr(2'd2, 32'h0000AB00);
        arm_wr(2'd1, 32'hE000_0000 | 32'(18'o777571));
        wait_for(0, 1'b1, 20, "datob_npr");
        bad = 0;
        repeat (50) begin
            if (!npr_out_h || bbsy_out_h || sack_out_h) bad++;
            @(negedge CLOCK);
        end
        chk("datob_grant_withheld", 64'(bad), 64'd0);
        grant();
        deskew_check(18'o777571, 2'b11, 16'hAB00);
        slave(0, 16'h0000, 0, "datob");

        // Byte DATI with no slave: word cycle, timeout, data register untouched.
        exp_q.push_back('{mk_r1(0, 0, 1, 1, 0, 18'o760000), 32'h0000AB00});
        arm_wr(2'd1, 32'hA000_0000 | 32'(18'o760000));
        grant();
        deskew_check(18'o760000, 2'b00, 16'h0000);
        n = 0;
        while (msyn_out_h && n < 2000) begin
            n++;
            @(negedge CLOCK);
        end
        chk("timeout_msyn_len", 64'(n), 64'(TIMEOUT));
        hold_check("timeout");

        // INIT during MSYN with a simultaneous new command.
        exp_q.push_back('{mk_r1(0, 1, 0, 0, 1, 18'o777570), 32'h00001234});
        arm_wr(2'd2, 32'h00001234);
        arm_wr(2'd1, 32'hC000_0000 | 32'(18'o777570));
        grant();
        deskew_check(18'o777570, 2'b10, 16'h1234);
        repeat (3) @(negedge CLOCK);
        init_in_h = 1'b1;
        armwaddr  = 2'd1;
        armwdata  = 32'h8000_0000 | 32'(18'o000123);
        armwrite  = 1'b1;
        @(negedge CLOCK);
        chk("init_outputs_cleared", bus_all(), 64'd0);
        init_in_h = 1'b0;
        armwrite  = 1'b0;
        bad = 0;
        repeat (10) begin
            @(negedge CLOCK);
            if (npr_out_h || bbsy_out_h) bad++;
        end
        chk("init_cmd_ignored", 64'(bad), 64'd0);

        repeat (3) @(negedge CLOCK);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
